intr_ctrl: RTL and testbench
============================

Name: intr_ctrl

Overview:
- Interrupt controller placed between the per-source interrupt latches (UART RX latch, timer, etc.) and the CPU core.
- Masks the level `irr` lines from N sources and picks one winner per interrupt using round-robin priority.
- Presents a single `intr`/`intr_id` request to the CPU and sequences the CPU's take/return handshake.
- Returns a one-cycle `src_ack` pulse to the winning source's latch so that the latch clears its `irr`.

Parameters:
- N_SRC, 4, number of interrupt sources (2..16).
- MASK_INIT, {N_SRC{1'b1}}, reset value of the enable mask.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- irr  in  N_SRC  level request from each source latch; held until that source receives `src_ack`.
- src_ack  out  N_SRC  one-hot, one-cycle clear pulse to the granted source latch.
- mask_we  in  1  mask write strobe.
- mask_wdata  in  N_SRC  new enable mask (1 = enabled).
- mask  out  N_SRC  current enable mask.
- intr  out  1  interrupt request to the CPU.
- intr_id  out  $clog2(N_SRC)  index of the requesting source; valid while `intr`=1.
- cpu_ack  in  1  CPU accepts the interrupt (handler entry).
- cpu_ret  in  1  CPU returns from the handler.
- busy  out  1  state != IDLE.

Behaviour:
- Outputs are registered. One clock `clk`; reset is synchronous and active-high on `reset`. Reset has priority over all other inputs.
- Reset values: state=IDLE, intr=0, intr_id=0, src_ack=0, busy=0, mask=MASK_INIT, last_grant=N_SRC-1. With last_grant=N_SRC-1, index 0 has highest priority first.
- eff = irr & mask.
- Round-robin pick: search indices last_grant+1, last_grant+2, ... modulo N_SRC. The first set bit of eff wins.
- State IDLE:
  - If eff != 0 at edge E, then after E: state=REQ, intr=1, intr_id=winner.
  - Otherwise remain in IDLE.
- State REQ:
  - intr=1 and intr_id is held stable.
  - If cpu_ack=1 at an edge, then after that edge: state=SERVICE, intr=0, src_ack[intr_id]=1 for exactly one cycle, last_grant=intr_id.
  - Withdrawal: if cpu_ack=0 and eff[intr_id]=0 (source dropped or masked), then after that edge: state=IDLE, intr=0, no src_ack, last_grant unchanged.
  - If cpu_ack and withdrawal occur on the same edge, cpu_ack wins.
- State SERVICE:
  - intr=0; newly pending requests stay pending (no nesting).
  - cpu_ret=1 at an edge moves state to IDLE after that edge.
  - Arbitration resumes at the following edge, so there is at least one IDLE cycle between interrupts.
- cpu_ack outside REQ and cpu_ret outside SERVICE are ignored.
- mask_we=1 at an edge: mask=mask_wdata after that edge. This is legal in any state. Masking the REQ source triggers withdrawal at the next edge.
- src_ack is the only path that clears a source. The controller never acks a source that was not taken by cpu_ack.
- Latency: irr rises before edge E → intr=1 after E. cpu_ack at E → src_ack pulse after E, in the same cycle that intr falls.
- Reset in any state (including mid-REQ/SERVICE): all outputs return to their reset values on that edge. Any src_ack in flight is cancelled.

Decomposition:
- Shared package intr_pkg holds:
  - enum intr_state_t {IDLE, REQ, SERVICE};
  - INTR_ID_W derived from N_SRC;
  - default N_SRC constant.
- Sub-module intr_rr_pick: combinational round-robin picker.
  - Inputs: eff, last_grant.
  - Outputs: any_req, winner.
- FSM, mask register and ack pulse live in intr_ctrl.

Test Plan (N_SRC=4, MASK_INIT=4'b1111):
1. Idle after reset: reset for 2 cycles, then irr=0 for 4 cycles → intr=0, intr_id=0, src_ack=0, busy=0 every cycle.
2. Single source:
   - irr=4'b0010 → next cycle intr=1, intr_id=1.
   - cpu_ack pulse → next cycle intr=0, src_ack=4'b0010 for 1 cycle, busy=1.
   - The bench drops irr; cpu_ret → busy=0; intr stays 0 for 4 cycles.
3. Round robin: irr=4'b1010 held, with the bench clearing a bit only on its src_ack and re-raising it one cycle later. Grant order must be intr_id = 1, 3, 1, 3, each grant completed with cpu_ack then cpu_ret.
4. Mask:
   - Write mask=4'b1101, irr=4'b0010 → intr=0 for 4 cycles, mask=4'b1101.
   - Write mask=4'b1111 → intr=1, intr_id=1 one cycle after the write takes effect.
5. Withdrawal and collision:
   - In REQ (id=2), drop irr[2] with cpu_ack=0 → intr=0 next cycle, src_ack stays 0, busy=0.
   - Repeat with irr[2] dropping on the same edge as cpu_ack=1 → src_ack=4'b0100 for one cycle, state SERVICE.
6. Reset mid-operation:
   - Write mask=4'b0001, take an interrupt to SERVICE, assert reset 1 cycle → intr=0, src_ack=0, busy=0, mask=4'b1111.
   - A later cpu_ret is ignored; with irr=4'b1001 the first grant is intr_id=0.

Source files
------------

// File: rtl/intr_pkg.sv
`default_nettype none
// ============================================================================
// Module  : intr_pkg
// Purpose : Shared types and constants for the interrupt controller slice.
//           Holds the controller state encoding and the default source count,
//           plus the id width derived from it.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package intr_pkg;

  localparam int N_SRC_DEFAULT = 4;
  localparam int INTR_ID_W     = $clog2(N_SRC_DEFAULT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } intr_state_t;

endpackage : intr_pkg
`default_nettype wire

// File: rtl/intr_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : intr_ctrl_if
// Purpose : Bundles the source-latch, mask-programming and CPU handshake
//           signals of the interrupt controller.
// Signals : irr        source level requests      (master -> slave)
//           src_ack    one-hot clear pulse        (slave  -> master)
//           mask_we    mask write strobe          (master -> slave)
//           mask_wdata new enable mask            (master -> slave)
//           mask       current enable mask        (slave  -> master)
//           intr       interrupt request to CPU   (slave  -> master)
//           intr_id    index of requesting source (slave  -> master)
//           cpu_ack    CPU handler entry          (master -> slave)
//           cpu_ret    CPU handler return         (master -> slave)
//           busy       controller not idle        (slave  -> master)
// Modports: slave = controller side, master = system/CPU side.
// Rev     : 1.0  initial release
// ============================================================================
interface intr_ctrl_if
  import intr_pkg::*;
#(
  parameter int N_SRC = N_SRC_DEFAULT
) ();

  localparam int ID_W = $clog2(N_SRC);

  logic [N_SRC-1:0] irr;
  logic [N_SRC-1:0] src_ack;
  logic             mask_we;
  logic [N_SRC-1:0] mask_wdata;
  logic [N_SRC-1:0] mask;
  logic             intr;
  logic [ID_W-1:0]  intr_id;
  logic             cpu_ack;
  logic             cpu_ret;
  logic             busy;

  modport slave (
    input  irr, mask_we, mask_wdata, cpu_ack, cpu_ret,
    output src_ack, mask, intr, intr_id, busy
  );

  modport master (
    output irr, mask_we, mask_wdata, cpu_ack, cpu_ret,
    input  src_ack, mask, intr, intr_id, busy
  );

endinterface : intr_ctrl_if
`default_nettype wire

// File: rtl/intr_rr_pick.sv
`default_nettype none
// ============================================================================
// Module  : intr_rr_pick
// Purpose : Combinational round-robin picker. Searches eff starting at
//           last_grant+1 and wrapping modulo N_SRC; the first set bit wins.
// Ports   : eff        in   N_SRC  masked requests
//           last_grant in   ID_W   index granted most recently
//           any_req    out  1      at least one bit of eff is set
//           winner     out  ID_W   winning index (0 when any_req=0)
// Rev     : 1.0  initial release
// ============================================================================
module intr_rr_pick
  import intr_pkg::*;
#(
  parameter int N_SRC = N_SRC_DEFAULT,
  localparam int ID_W = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] eff,
  input  logic [ID_W-1:0]  last_grant,
  output logic             any_req,
  output logic [ID_W-1:0]  winner
);

  // One extra bit so last_grant + offset (at most 2*N_SRC-1) never overflows
  // before the modulo wrap.
  logic [ID_W:0]   idx;
  logic [ID_W-1:0] sel;

  always_comb begin
    any_req = 1'b0;
    winner  = '0;
    idx     = '0;
    sel     = '0;
    for (int i = 1; i <= N_SRC; i++) begin
      idx = {1'b0, last_grant} + (ID_W+1)'(i);
      if (idx >= (ID_W+1)'(N_SRC)) begin
        idx = idx - (ID_W+1)'(N_SRC);
      end
      // After the wrap idx < N_SRC, so the low ID_W bits hold it exactly.
      sel = idx[ID_W-1:0];
      if (!any_req && eff[sel]) begin
        any_req = 1'b1;
        winner  = sel;
      end
    end
  end

endmodule : intr_rr_pick
`default_nettype wire

// File: rtl/intr_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : intr_ctrl
// Purpose : Interrupt controller between per-source request latches and the
//           CPU. Masks irr, picks a winner round-robin, presents intr/intr_id,
//           runs the cpu_ack/cpu_ret handshake and pulses src_ack to clear the
//           taken source's latch. All outputs are registered.
// Ports   : clk    in  system clock, rising edge
//           reset  in  synchronous active-high reset
//           bus    slave modport of intr_ctrl_if (irr, src_ack, mask_we,
//                  mask_wdata, mask, intr, intr_id, cpu_ack, cpu_ret, busy)
// Rev     : 1.0  initial release
// ============================================================================
module intr_ctrl
  import intr_pkg::*;
#(
  parameter int               N_SRC     = N_SRC_DEFAULT,
  parameter logic [N_SRC-1:0] MASK_INIT = {N_SRC{1'b1}}
) (
  input  logic        clk,
  input  logic        reset,
  intr_ctrl_if.slave  bus
);

  localparam int ID_W = $clog2(N_SRC);

  intr_state_t      state;
  logic [ID_W-1:0]  last_grant;
  logic [N_SRC-1:0] mask_q;
  logic [N_SRC-1:0] eff;
  logic             any_req;
  logic [ID_W-1:0]  winner;

  // Uses the registered mask, so a mask write only influences arbitration
  // and withdrawal from the edge after it lands.
  assign eff      = bus.irr & mask_q;
  assign bus.mask = mask_q;

  intr_rr_pick #(
    .N_SRC      (N_SRC)
  ) u_pick (
    .eff        (eff),
    .last_grant (last_grant),
    .any_req    (any_req),
    .winner     (winner)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      bus.intr    <= 1'b0;
      bus.intr_id <= '0;
      bus.src_ack <= '0;
      bus.busy    <= 1'b0;
      mask_q      <= MASK_INIT;
      // Start one below 0 so index 0 has the highest priority after reset.
      last_grant  <= ID_W'(N_SRC-1);
    end else begin
      // src_ack is a single-cycle pulse; only the REQ->SERVICE step sets it.
      bus.src_ack <= '0;

      if (bus.mask_we) begin
        mask_q <= bus.mask_wdata;
      end

      case (state)
        IDLE: begin
          if (any_req) begin
            state       <= REQ;
            bus.intr    <= 1'b1;
            bus.intr_id <= winner;
            bus.busy    <= 1'b1;
          end
        end

        REQ: begin
          // cpu_ack beats a same-edge withdrawal: the CPU has already taken it.
          if (bus.cpu_ack) begin
            state       <= SERVICE;
            bus.intr    <= 1'b0;
            bus.src_ack <= {{(N_SRC-1){1'b0}}, 1'b1} << bus.intr_id;
            last_grant  <= bus.intr_id;
          end else if (!eff[bus.intr_id]) begin
            state    <= IDLE;
            bus.intr <= 1'b0;
            bus.busy <= 1'b0;
          end
        end

        SERVICE: begin
          // No nesting: pending requests wait until the handler returns.
          if (bus.cpu_ret) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        end

        default: begin
          state    <= IDLE;
          bus.intr <= 1'b0;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule : intr_ctrl
`default_nettype wire

// File: tb/tb_intr_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_intr_ctrl
// Purpose : Directed self-checking bench for intr_ctrl (N_SRC=4,
//           MASK_INIT=4'b1111). Inputs change 1 time unit after each rising
//           edge; outputs are sampled at the same point.
// Ports   : none
// Rev     : 1.0  initial release
// ============================================================================
module tb_intr_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  intr_ctrl_if #(.N_SRC(4)) bus ();

  intr_ctrl #(
    .N_SRC     (4),
    .MASK_INIT (4'b1111)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.irr = '0; bus.mask_we = 1'b0; bus.mask_wdata = '0;
    bus.cpu_ack = 1'b0; bus.cpu_ret = 1'b0;
    tick(); tick();
    reset = 1'b0;
    if (bus.mask !== 4'b1111) $display("FAIL reset_mask: got %b want 1111", bus.mask); else n_pass++; n_total++;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.intr !== 1'b0) $display("FAIL idle_intr[%0d]: got %b want 0", i, bus.intr); else n_pass++; n_total++;
      if (bus.intr_id !== 2'd0) $display("FAIL idle_id[%0d]: got %0d want 0", i, bus.intr_id); else n_pass++; n_total++;
      if (bus.src_ack !== 4'b0000) $display("FAIL idle_ack[%0d]: got %b want 0000", i, bus.src_ack); else n_pass++; n_total++;
      if (bus.busy !== 1'b0) $display("FAIL idle_busy[%0d]: got %b want 0", i, bus.busy); else n_pass++; n_total++;
    end
  endtask

  task automatic test_single();
    bus.irr = 4'b0010;
    tick();
    if (bus.intr !== 1'b1) $display("FAIL single_intr: got %b want 1", bus.intr); else n_pass++; n_total++;
    if (bus.intr_id !== 2'd1) $display("FAIL single_id: got %0d want 1", bus.intr_id); else n_pass++; n_total++;
    tick(); tick();
    if (bus.intr !== 1'b1 || bus.intr_id !== 2'd1) $display("FAIL single_hold: got intr=%b id=%0d want 1/1", bus.intr, bus.intr_id); else n_pass++; n_total++;
    bus.cpu_ack = 1'b1;
    tick();
    bus.cpu_ack = 1'b0;
    if (bus.intr !== 1'b0) $display("FAIL single_ack_intr: got %b want 0", bus.intr); else n_pass++; n_total++;
    if (bus.src_ack !== 4'b0010) $display("FAIL single_src_ack: got %b want 0010", bus.src_ack); else n_pass++; n_total++;
    if (bus.busy !== 1'b1) $display("FAIL single_busy: got %b want 1", bus.busy); else n_pass++; n_total++;
    bus.irr = 4'b0000;
    tick();
    if (bus.src_ack !== 4'b0000) $display("FAIL single_ack_pulse: got %b want 0000", bus.src_ack); else n_pass++; n_total++;
    bus.cpu_ret = 1'b1;
    tick();
    bus.cpu_ret = 1'b0;
    if (bus.busy !== 1'b0) $display("FAIL single_ret_busy: got %b want 0", bus.busy); else n_pass++; n_total++;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.intr !== 1'b0) $display("FAIL single_quiet[%0d]: got %b want 0", i, bus.intr); else n_pass++; n_total++;
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_id [4];
    logic [3:0] exp_ack;
    exp_id[0] = 2'd1; exp_id[1] = 2'd3; exp_id[2] = 2'd1; exp_id[3] = 2'd3;
    // Fresh reset so index 0 is first in line and the order is 1,3,1,3.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.irr = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (bus.intr !== 1'b1 || bus.intr_id !== exp_id[k]) $display("FAIL rr_grant[%0d]: got intr=%b id=%0d want 1/%0d", k, bus.intr, bus.intr_id, exp_id[k]); else n_pass++; n_total++;
      bus.cpu_ack = 1'b1;
      tick();
      bus.cpu_ack = 1'b0;
      exp_ack = 4'b0001 << exp_id[k];
      if (bus.src_ack !== exp_ack) $display("FAIL rr_ack[%0d]: got %b want %b", k, bus.src_ack, exp_ack); else n_pass++; n_total++;
      bus.irr = bus.irr & ~bus.src_ack;
      tick();
      bus.irr = 4'b1010;
      bus.cpu_ret = 1'b1;
      tick();
      bus.cpu_ret = 1'b0;
    end
    bus.irr = 4'b0000;
    tick();
    if (bus.busy !== 1'b0) $display("FAIL rr_done_busy: got %b want 0", bus.busy); else n_pass++; n_total++;
  endtask

  task automatic test_mask();
    bus.mask_we = 1'b1; bus.mask_wdata = 4'b1101;
    tick();
    bus.mask_we = 1'b0;
    if (bus.mask !== 4'b1101) $display("FAIL mask_write: got %b want 1101", bus.mask); else n_pass++; n_total++;
    bus.irr = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.intr !== 1'b0) $display("FAIL mask_blocked[%0d]: got %b want 0", i, bus.intr); else n_pass++; n_total++;
    end
    bus.mask_we = 1'b1; bus.mask_wdata = 4'b1111;
    tick();
    bus.mask_we = 1'b0;
    if (bus.intr !== 1'b0 || bus.mask !== 4'b1111) $display("FAIL mask_unmask_edge: got intr=%b mask=%b want 0/1111", bus.intr, bus.mask); else n_pass++; n_total++;
    tick();
    if (bus.intr !== 1'b1 || bus.intr_id !== 2'd1) $display("FAIL mask_unmask_req: got intr=%b id=%0d want 1/1", bus.intr, bus.intr_id); else n_pass++; n_total++;
    // Masking the source in REQ withdraws it one edge after the write lands.
    bus.mask_we = 1'b1; bus.mask_wdata = 4'b1101;
    tick();
    bus.mask_we = 1'b0;
    if (bus.intr !== 1'b1) $display("FAIL mask_wd_wait: got %b want 1", bus.intr); else n_pass++; n_total++;
    tick();
    if (bus.intr !== 1'b0 || bus.busy !== 1'b0 || bus.src_ack !== 4'b0000) $display("FAIL mask_withdraw: got intr=%b busy=%b ack=%b want 0/0/0000", bus.intr, bus.busy, bus.src_ack); else n_pass++; n_total++;
    bus.irr = 4'b0000;
    bus.mask_we = 1'b1; bus.mask_wdata = 4'b1111;
    tick();
    bus.mask_we = 1'b0;
  endtask

  task automatic test_withdraw();
    bus.irr = 4'b0100;
    tick();
    if (bus.intr !== 1'b1 || bus.intr_id !== 2'd2) $display("FAIL wd_req: got intr=%b id=%0d want 1/2", bus.intr, bus.intr_id); else n_pass++; n_total++;
    bus.irr = 4'b0000;
    tick();
    if (bus.intr !== 1'b0 || bus.src_ack !== 4'b0000 || bus.busy !== 1'b0) $display("FAIL wd_drop: got intr=%b ack=%b busy=%b want 0/0000/0", bus.intr, bus.src_ack, bus.busy); else n_pass++; n_total++;
    bus.irr = 4'b0100;
    tick();
    if (bus.intr !== 1'b1 || bus.intr_id !== 2'd2) $display("FAIL coll_req: got intr=%b id=%0d want 1/2", bus.intr, bus.intr_id); else n_pass++; n_total++;
    bus.irr = 4'b0000; bus.cpu_ack = 1'b1;
    tick();
    bus.cpu_ack = 1'b0;
    if (bus.src_ack !== 4'b0100 || bus.intr !== 1'b0 || bus.busy !== 1'b1) $display("FAIL coll_ack: got ack=%b intr=%b busy=%b want 0100/0/1", bus.src_ack, bus.intr, bus.busy); else n_pass++; n_total++;
    tick();
    if (bus.src_ack !== 4'b0000 || bus.busy !== 1'b1) $display("FAIL coll_service: got ack=%b busy=%b want 0000/1", bus.src_ack, bus.busy); else n_pass++; n_total++;
    bus.cpu_ret = 1'b1;
    tick();
    bus.cpu_ret = 1'b0;
    // A stray cpu_ack while idle must not produce an ack.
    bus.cpu_ack = 1'b1;
    tick();
    bus.cpu_ack = 1'b0;
    if (bus.src_ack !== 4'b0000 || bus.busy !== 1'b0) $display("FAIL idle_stray_ack: got ack=%b busy=%b want 0000/0", bus.src_ack, bus.busy); else n_pass++; n_total++;
  endtask

  task automatic test_reset_mid();
    bus.mask_we = 1'b1; bus.mask_wdata = 4'b0001;
    tick();
    bus.mask_we = 1'b0;
    bus.irr = 4'b0001;
    tick();
    if (bus.intr !== 1'b1 || bus.intr_id !== 2'd0) $display("FAIL rst_pre_req: got intr=%b id=%0d want 1/0", bus.intr, bus.intr_id); else n_pass++; n_total++;
    bus.cpu_ack = 1'b1;
    tick();
    bus.cpu_ack = 1'b0;
    bus.irr = 4'b0000;
    tick();
    if (bus.busy !== 1'b1) $display("FAIL rst_pre_service: got busy=%b want 1", bus.busy); else n_pass++; n_total++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    if (bus.intr !== 1'b0 || bus.src_ack !== 4'b0000 || bus.busy !== 1'b0) $display("FAIL rst_mid_outs: got intr=%b ack=%b busy=%b want 0/0000/0", bus.intr, bus.src_ack, bus.busy); else n_pass++; n_total++;
    if (bus.mask !== 4'b1111) $display("FAIL rst_mid_mask: got %b want 1111", bus.mask); else n_pass++; n_total++;
    bus.cpu_ret = 1'b1;
    tick();
    bus.cpu_ret = 1'b0;
    if (bus.busy !== 1'b0 || bus.intr !== 1'b0) $display("FAIL rst_stray_ret: got busy=%b intr=%b want 0/0", bus.busy, bus.intr); else n_pass++; n_total++;
    bus.irr = 4'b1001;
    tick();
    if (bus.intr !== 1'b1 || bus.intr_id !== 2'd0) $display("FAIL rst_first_grant: got intr=%b id=%0d want 1/0", bus.intr, bus.intr_id); else n_pass++; n_total++;
    // Reset on the same edge as cpu_ack cancels the ack pulse.
    bus.cpu_ack = 1'b1; reset = 1'b1;
    tick();
    bus.cpu_ack = 1'b0; reset = 1'b0;
    if (bus.src_ack !== 4'b0000 || bus.intr !== 1'b0 || bus.busy !== 1'b0) $display("FAIL rst_cancel_ack: got ack=%b intr=%b busy=%b want 0000/0/0", bus.src_ack, bus.intr, bus.busy); else n_pass++; n_total++;
    tick();
    if (bus.intr !== 1'b1 || bus.intr_id !== 2'd0) $display("FAIL rst_regrant: got intr=%b id=%0d want 1/0", bus.intr, bus.intr_id); else n_pass++; n_total++;
    bus.irr = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_mask();
    test_withdraw();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_intr_ctrl
`default_nettype wire
